// File: rtl/memory_bank_scan_ctrl.sv
// Flop-based storage bank with memory-mapped I/O channels and a serial scan
// controller. The scan controller dumps or loads the whole bank one bit per
// cycle, LSB-first within a word, in ascending word order.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | bus port open (ready=1); waits for scan_start
// SHIFT | one scan bit per cycle over all words; bus port closed
// DONE  | one-cycle scan_done pulse, then back to IDLE
module memory_bank_scan_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 240,
    parameter int NUM_IO     = 4,
    parameter int IO_BASE    = 248
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic                         ready,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         rvalid,
    input  logic [NUM_IO*DATA_WIDTH-1:0] io_in,
    output logic [NUM_IO*DATA_WIDTH-1:0] io_out,
    input  logic                         scan_start,
    input  logic                         scan_load,
    input  logic                         scan_in,
    output logic                         scan_out,
    output logic                         scan_valid,
    output logic                         scan_busy,
    output logic                         scan_done
);

    localparam int WCW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(MEM_DEPTH - 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                       state, state_nxt;
    logic                         mode_load;
    logic [WCW-1:0]               word_cnt;
    logic [BCW-1:0]               bit_cnt;
    logic [DATA_WIDTH-1:0]        asm_q;
    logic [DATA_WIDTH-1:0]        mem [MEM_DEPTH];
    logic [NUM_IO*DATA_WIDTH-1:0] sync1, sync2;
    logic [DATA_WIDTH-1:0]        rd_mux;
    logic [31:0]                  addr_i;
    logic                         accept, wr_en, rd_en, last_bit, last_word;

    assign addr_i    = 32'(addr);
    assign accept    = req && ready;
    assign wr_en     = accept && we;
    assign rd_en     = accept && !we;
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign last_word = (word_cnt == LAST_WORD);

    // Dump data comes straight from the addressed bit; quiet outside dump slots.
    assign scan_out = (scan_valid && !mode_load) ? mem[word_cnt][bit_cnt] : 1'b0;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and per-state status outputs
    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        scan_valid = 1'b0;
        scan_busy  = 1'b1;
        scan_done  = 1'b0;
        case (state)
            IDLE: begin
                ready     = 1'b1;
                scan_busy = 1'b0;
                if (scan_start) state_nxt = SHIFT;
            end
            SHIFT: begin
                scan_valid = 1'b1;
                if (last_bit && last_word) state_nxt = DONE;
            end
            DONE: begin
                scan_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Scan mode latch, word/bit position counters and load assembly shifter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_load <= 1'b0;
            word_cnt  <= '0;
            bit_cnt   <= '0;
            asm_q     <= '0;
        end else if (state == IDLE && scan_start) begin
            mode_load <= scan_load;
            word_cnt  <= '0;
            bit_cnt   <= '0;
            asm_q     <= '0;
        end else if (state == SHIFT) begin
            // Shifting in from the top leaves bits 0..W-2 in asm_q[W-1:1]
            // by the time the last bit of a word arrives.
            asm_q <= {scan_in, asm_q[DATA_WIDTH-1:1]};
            if (last_bit) begin
                bit_cnt  <= '0;
                word_cnt <= last_word ? '0 : word_cnt + WCW'(1);
            end else begin
                bit_cnt  <= bit_cnt + BCW'(1);
            end
        end
    end

    // Storage words: bus writes in IDLE, whole-word scan loads in SHIFT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (wr_en && addr_i < MEM_DEPTH) begin
            mem[addr[WCW-1:0]] <= wdata;
        end else if (state == SHIFT && mode_load && last_bit) begin
            mem[word_cnt] <= {scan_in, asm_q[DATA_WIDTH-1:1]};
        end
    end

    // Output channel registers, written only at their even addresses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_out <= '0;
        end else begin
            for (int k = 0; k < NUM_IO; k++)
                if (wr_en && addr_i == 32'(IO_BASE + 2 * k))
                    io_out[k*DATA_WIDTH +: DATA_WIDTH] <= wdata;
        end
    end

    // Two-flop synchroniser on every input pin bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= io_in;
            sync2 <= sync1;
        end
    end

    // Read address decode; unmapped addresses read as zero
    always_comb begin
        rd_mux = '0;
        if (addr_i < MEM_DEPTH) rd_mux = mem[addr[WCW-1:0]];
        for (int k = 0; k < NUM_IO; k++) begin
            if (addr_i == 32'(IO_BASE + 2 * k))
                rd_mux = io_out[k*DATA_WIDTH +: DATA_WIDTH];
            if (addr_i == 32'(IO_BASE + 2 * k + 1))
                rd_mux = sync2[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Registered read data with a one-cycle valid pulse per accepted read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_memory_bank_scan_ctrl.sv
// Self-checking bench for memory_bank_scan_ctrl: directed bus/I-O cases,
// randomized bus traffic against an array model, scan dump/load and
// reset-during-scan.
module tb_memory_bank_scan_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 240;
    localparam int NIO   = 4;
    localparam int IOB   = 248;
    localparam int NBITS = DEPTH * DW;

    logic            clk = 1'b0;
    logic            rst;
    logic            req, we;
    logic [7:0]      addr, wdata;
    logic            ready;
    logic [DW-1:0]   rdata;
    logic            rvalid;
    logic [NIO*DW-1:0] io_in, io_out;
    logic            scan_start, scan_load, scan_in;
    logic            scan_out, scan_valid, scan_busy, scan_done;

    memory_bank_scan_ctrl #(
        .ADDR_WIDTH(8), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
        .NUM_IO(NIO), .IO_BASE(IOB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .rvalid(rvalid),
        .io_in(io_in), .io_out(io_out),
        .scan_start(scan_start), .scan_load(scan_load), .scan_in(scan_in),
        .scan_out(scan_out), .scan_valid(scan_valid), .scan_busy(scan_busy),
        .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mem_m [DEPTH];
    logic [7:0] io_m  [NIO];
    logic [7:0] last_rd;
    logic [7:0] dump_words [DEPTH];
    logic [7:0] load_words [DEPTH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] io_pack();
        logic [31:0] v;
        for (int k = 0; k < NIO; k++) v[k*8 +: 8] = io_m[k];
        return v;
    endfunction

    // Expected read value; pins are assumed stable for at least two edges.
    function automatic logic [7:0] model_read(input int a, input logic [31:0] pins);
        int ch;
        if (a < DEPTH) return mem_m[a];
        if (a >= IOB && a < IOB + 2 * NIO) begin
            ch = (a - IOB) / 2;
            if (((a - IOB) % 2) == 0) return io_m[ch];
            return pins[ch*8 +: 8];
        end
        return 8'h00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        for (int k = 0; k < NIO; k++) io_m[k] = 8'h00;
        last_rd = 8'h00;
    endtask

    task automatic bus_write(input int a, input logic [7:0] d);
        req = 1'b1; we = 1'b1; addr = 8'(a); wdata = d;
        step();
        req = 1'b0; we = 1'b0;
        if (a < DEPTH) mem_m[a] = d;
        else if (a >= IOB && a < IOB + 2 * NIO && ((a - IOB) % 2) == 0) io_m[(a - IOB) / 2] = d;
        check_val("wr_io_out", io_out, io_pack());
        check_val("wr_no_rvalid", rvalid, 0);
        check_val("wr_rdata_hold", rdata, last_rd);
    endtask

    task automatic bus_read(input int a);
        logic [7:0] exp;
        exp = model_read(a, io_in);
        req = 1'b1; we = 1'b0; addr = 8'(a);
        step();
        req = 1'b0;
        last_rd = exp;
        check_val("rd_rvalid", rvalid, 1);
        check_val($sformatf("rd_data_a%0d", a), rdata, exp);
    endtask

    // Runs from the first SHIFT sample until the controller is idle again.
    task automatic run_scan(input bit load_mode, input bit check_rvalid);
        int nbits, nbusy, ndone, bad_ready, bad_out, bad_rv;
        bit finished;
        nbits = 0; nbusy = 0; ndone = 0; bad_ready = 0; bad_out = 0; bad_rv = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (scan_valid && nbits < NBITS) begin
                if (load_mode) scan_in = load_words[nbits / DW][nbits % DW];
                else           dump_words[nbits / DW][nbits % DW] = scan_out;
                nbits++;
            end else begin
                scan_in = 1'b0;
                if (scan_out) bad_out++;
            end
            if (scan_busy) nbusy++;
            if (ready == scan_busy) bad_ready++;
            if (scan_done) ndone++;
            if (check_rvalid && scan_busy && rvalid) bad_rv++;
            if (!scan_busy) begin
                scan_start = 1'b0; scan_load = 1'b0;
                finished = 1'b1;
                break;
            end
            scan_start = 1'($urandom_range(0, 1));
            scan_load  = 1'($urandom_range(0, 1));
            step();
        end
        scan_in = 1'b0;
        check_val("scan_finished", finished, 1);
        check_val("scan_valid_cycles", nbits, NBITS);
        check_val("scan_busy_cycles", nbusy, NBITS + 1);
        check_val("scan_done_pulses", ndone, 1);
        check_val("scan_ready_vs_busy", bad_ready, 0);
        check_val("scan_out_quiet", bad_out, 0);
        check_val("scan_no_rvalid", bad_rv, 0);
    endtask

    task automatic check_dump();
        for (int w = 0; w < DEPTH; w++)
            check_val($sformatf("dump_w%0d", w), dump_words[w], mem_m[w]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, r;
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        io_in = '0; scan_start = 1'b0; scan_load = 1'b0; scan_in = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        check_val("rst_ready", ready, 1);
        check_val("rst_rvalid", rvalid, 0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_io_out", io_out, 0);
        check_val("rst_busy", scan_busy, 0);
        check_val("rst_scan_out", scan_out, 0);

        // Reset-state reads, one rvalid per accept
        bus_read(0);
        bus_read(248);
        bus_read(249);
        step();
        check_val("rvalid_one_cycle", rvalid, 0);

        // Memory and output-channel write/read
        bus_write(3, 8'hA5);
        bus_read(3);
        bus_write(250, 8'h7F);
        check_val("io_ch1_same_edge", io_out[15:8], 8'h7F);
        bus_read(250);

        // Input synchroniser latency with back-to-back reads of channel 3
        io_in[31:24] = 8'h3C;
        req = 1'b1; we = 1'b0; addr = 8'd255;
        step();
        check_val("sync_e1_rv", rvalid, 1);
        check_val("sync_e1", rdata, 8'h00);
        step();
        check_val("sync_e2_rv", rvalid, 1);
        check_val("sync_e2", rdata, 8'h00);
        step();
        check_val("sync_e3_rv", rvalid, 1);
        check_val("sync_e3", rdata, 8'h3C);
        req = 1'b0;
        last_rd = 8'h3C;
        bus_write(255, 8'h11);
        bus_write(244, 8'h99);
        bus_read(244);

        // Randomized bus traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 2);
            if (r == 0)      a = $urandom_range(0, 255);
            else if (r == 1) a = $urandom_range(0, 7);
            else             a = $urandom_range(240, 255);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                io_in = $urandom;
                step();
                step();
            end else if (r < 5) begin
                bus_write(a, 8'($urandom));
            end else begin
                bus_read(a);
            end
        end

        // Dump with a read accepted in the same cycle as scan_start
        bus_write(0, 8'h01);
        bus_write(1, 8'h80);
        scan_start = 1'b1; scan_load = 1'b0;
        req = 1'b1; we = 1'b0; addr = 8'd1;
        step();
        req = 1'b0;
        last_rd = 8'h80;
        check_val("start_rd_rvalid", rvalid, 1);
        check_val("start_rd_data", rdata, 8'h80);
        check_val("start_in_shift", scan_valid, 1);
        run_scan(1'b0, 1'b0);
        check_val("dump_bits_0_7", dump_words[0], 8'h01);
        check_val("dump_bits_8_15", dump_words[1], 8'h80);
        check_dump();
        check_val("dump_ready_after", ready, 1);
        bus_read(0);
        bus_read(1);

        // Load the whole bank serially while a read is held pending
        for (int w = 0; w < DEPTH; w++) load_words[w] = 8'($urandom);
        load_words[0] = 8'hC3;
        load_words[1] = 8'h00;
        load_words[DEPTH-1] = 8'h5A;
        scan_start = 1'b1; scan_load = 1'b1;
        step();
        req = 1'b1; we = 1'b0; addr = 8'd0;
        run_scan(1'b1, 1'b1);
        for (int w = 0; w < DEPTH; w++) mem_m[w] = load_words[w];
        step();
        req = 1'b0;
        last_rd = 8'hC3;
        check_val("held_rd_rvalid", rvalid, 1);
        check_val("held_rd_data", rdata, 8'hC3);
        for (int w = 0; w < DEPTH; w++) bus_read(w);

        // Reset in the middle of a dump
        scan_start = 1'b1; scan_load = 1'b0;
        step();
        scan_start = 1'b0;
        repeat (100) step();
        check_val("pre_rst_shift", scan_valid, 1);
        #2 rst = 1'b0;
        #1;
        clear_model();
        check_val("arst_valid", scan_valid, 0);
        check_val("arst_busy", scan_busy, 0);
        check_val("arst_done", scan_done, 0);
        check_val("arst_ready", ready, 1);
        check_val("arst_scan_out", scan_out, 0);
        check_val("arst_rdata", rdata, 0);
        check_val("arst_rvalid", rvalid, 0);
        check_val("arst_io_out", io_out, 0);
        @(posedge clk);
        #1;
        check_val("arst_no_done", scan_done, 0);
        @(negedge clk) rst = 1'b1;
        #1;
        bus_read(0);
        bus_read(DEPTH - 1);
        bus_write(5, 8'h55);
        scan_start = 1'b1; scan_load = 1'b0;
        step();
        run_scan(1'b0, 1'b0);
        check_dump();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
